sr_latch_monitor: RTL and testbench
===================================

# sr_latch_monitor

Clocked checker that sits at the far end of the SR-latch stimulus interface. It samples the R and S drive lines and the latch output Q each cycle. It maintains a reference model of the expected Q and flags every cycle where the latch disagrees once a settle window has elapsed. It also counts set/reset commands and errors, and flags the forbidden S=R=1 input. It is instantiated alongside the latch under test in the SR-latch simulation top and replaces waveform inspection.

## Interface
- SETTLE, 2: cycles after a new set/reset command during which Q is not compared; 0..15.
- CNT_W, 8: width of every counter output.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- r  in  1  latch reset input (same net driven into the latch).
- s  in  1  latch set input.
- q  in  1  latch output under check.
- clr  in  1  synchronous clear of counters and flags.
- exp_q  out  1  model-expected Q.
- valid  out  1  exp_q is defined, i.e. state is SETTLING or CHECK.
- state  out  2  UNKNOWN=0, SETTLING=1, CHECK=2, ILLEGAL=3.
- err  out  1  mismatch indication.
- illegal  out  1  S=R=1 has been sampled; sticky.
- err_cnt  out  CNT_W  mismatching compare cycles; saturating.
- set_cnt  out  CNT_W  new set commands; saturating.
- rst_cnt  out  CNT_W  new reset commands; saturating.

## Operation
- Sampling and commands:
  - r, s and q are sampled on every rising clk; all outputs are registered.
  - Commands: set = s&~r; reset = r&~s; hold = ~r&~s; forbid = r&s.
  - A "new" command is one whose sampled {r,s} differs from the previous sample. The previous-sample register resets to 00.
- Reset values: state UNKNOWN, exp_q 0, valid 0, err 0, illegal 0, all counters 0.
- New set or reset, from any state:
  - exp_q takes 1 for set, 0 for reset.
  - set_cnt or rst_cnt increments.
  - state goes to SETTLING with the settle counter loaded with SETTLE.
  - If SETTLE=0, state goes directly to CHECK.
- A set or reset that is held (not new) changes nothing.
- Hold: no change to exp_q or state. The settle countdown continues in SETTLING.
- Forbid, from any state:
  - state goes to ILLEGAL; illegal is set to 1; valid goes to 0; exp_q is held.
  - ILLEGAL is left only by a new set or reset. Hold keeps the state in ILLEGAL.
- SETTLING:
  - The settle counter decrements each edge.
  - At the edge where the counter is 1, state goes to CHECK.
  - Q is never compared in SETTLING.
- CHECK: on each edge where q != exp_q, err_cnt increments (saturating at all-ones) and err asserts.
- No compares occur in UNKNOWN or ILLEGAL.
- clr:
  - Zeroes err, illegal, err_cnt, set_cnt and rst_cnt.
  - Does not affect state, exp_q or the settle counter.
  - If clr and a counting event fall on the same edge, clr wins and the counter reads 0.
- Saturation: counters stop at 2^CNT_W-1 and never wrap.

## Timing
- Let a new command be sampled at edge k. Then exp_q, state, valid and the command counters update at edge k.
- For SETTLE>0, state becomes CHECK at edge k+SETTLE. The first Q compare happens at edge k+SETTLE+1.
- For SETTLE=0, the first Q compare happens at edge k+1.
- A mismatch compared at edge m makes err=1 and err_cnt+1 visible after edge m.
- A new command arriving during SETTLING restarts the window from that edge.
- Stimulus must change r, s and q away from the rising edge; only edge samples matter.
- Asserting rst at any time returns every output to its reset value immediately, without waiting for a clock edge.
- The first edge after rst deassertion samples normally. Its {r,s} is compared against the reset value 00.

## Configuration
- SR_MON_STICKY_ERR_EN undefined:
  - err is a one-cycle pulse, high after each mismatching compare edge and low after any edge with no mismatch.
- SR_MON_STICKY_ERR_EN defined:
  - err goes to 1 on the first mismatch and stays 1 until clr or rst.
  - err_cnt behaviour is identical in both builds.

## Test plan
- SETTLE=2; r,s=00 for 5 cycles -> state UNKNOWN, valid 0, no compares, err_cnt 0.
- s=1 at edge k with q rising at k+1 -> exp_q 1, set_cnt 1, state CHECK at k+2, err never asserts.
- Sequence S, R, hold, S, hold (100 cycles each) with a correct latch -> set_cnt 2, rst_cnt 1, err_cnt 0, exp_q ends at 1.
- After set, force q=0 for 3 CHECK cycles:
  - err_cnt 3 in both builds.
  - Non-sticky build: err pulses 3 cycles.
  - Sticky build: err stays 1 until clr, then err and err_cnt read 0.
- r=s=1 for 1 cycle then 00 -> state ILLEGAL, illegal 1, valid 0, no compares; a following s=1 -> SETTLING, illegal still 1 until clr.
- Assert rst mid-SETTLING and CNT_W=2 with 5 mismatches:
  - Asserting rst mid-SETTLING returns all outputs to reset values before the next edge.
  - With CNT_W=2 and 5 mismatches, err_cnt saturates at 3.

Source files
------------

// File: rtl/sr_latch_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_monitor
// Purpose  : Clocked checker for an SR latch. Samples the latch drive lines
//            (r, s) and the latch output (q) on every rising clk, keeps a
//            reference model of the expected Q, and flags every compare cycle
//            in which the latch disagrees once a settle window has elapsed.
//            Also counts new set/reset commands and mismatches, and flags the
//            forbidden r=s=1 input (sticky).
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high reset
//            r, s     - latch reset / set drive lines (same nets as the latch)
//            q        - latch output under check
//            clr      - synchronous clear of counters and flags
//            exp_q    - model-expected Q
//            valid    - exp_q defined (state SETTLING or CHECK)
//            state    - UNKNOWN=0, SETTLING=1, CHECK=2, ILLEGAL=3
//            err      - mismatch indication
//            illegal  - r=s=1 has been sampled (sticky until clr/rst)
//            err_cnt  - mismatching compare cycles (saturating)
//            set_cnt  - new set commands (saturating)
//            rst_cnt  - new reset commands (saturating)
// Config   : SR_MON_STICKY_ERR_EN - when defined, err stays high after the
//            first mismatch until clr or rst; otherwise err is a one-cycle
//            pulse per mismatching compare edge.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_monitor #(
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r,
   input  logic             s,
   input  logic             q,
   input  logic             clr,
   output logic             exp_q,
   output logic             valid,
   output logic [1:0]       state,
   output logic             err,
   output logic             illegal,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] set_cnt,
   output logic [CNT_W-1:0] rst_cnt
);

   typedef enum logic [1:0] {
      ST_UNKNOWN  = 2'd0,
      ST_SETTLING = 2'd1,
      ST_CHECK    = 2'd2,
      ST_ILLEGAL  = 2'd3
   } state_t;

   localparam logic [3:0]       C_SETTLE = 4'(SETTLE);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + C_ONE;
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [1:0]       rs_prev_q, rs_prev_d;
   logic             exp_bit_q, exp_bit_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
   logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;

   logic is_new;
   logic cmd_set;
   logic cmd_rst;
   logic cmd_forbid;
   logic mismatch;

   always_comb begin
      rs_prev_d  = {r, s};
      is_new     = ({r, s} != rs_prev_q);
      cmd_set    = s & ~r;
      cmd_rst    = r & ~s;
      cmd_forbid = r & s;

      // The compare uses the state and expectation held before this edge, so a
      // command arriving in CHECK is judged against the previous expectation.
      mismatch   = (state_q == ST_CHECK) && (q != exp_bit_q);

      state_d    = state_q;
      settle_d   = settle_q;
      exp_bit_d  = exp_bit_q;

      if (cmd_forbid) begin
         state_d = ST_ILLEGAL;
      end else if ((cmd_set || cmd_rst) && is_new) begin
         exp_bit_d = cmd_set;
         if (SETTLE == 0) begin
            state_d = ST_CHECK;
         end else begin
            state_d  = ST_SETTLING;
            settle_d = C_SETTLE;
         end
      end else if (state_q == ST_SETTLING) begin
         // Hold or a held set/reset lets the countdown run; leave at count 1.
         if (settle_q <= 4'd1) begin
            state_d = ST_CHECK;
         end
         settle_d = (settle_q != 4'd0) ? settle_q - 4'd1 : 4'd0;
      end

      valid_d = (state_d == ST_SETTLING) || (state_d == ST_CHECK);

      err_cnt_d = mismatch ? sat_inc(err_cnt_q) : err_cnt_q;
      set_cnt_d = (cmd_set && is_new) ? sat_inc(set_cnt_q) : set_cnt_q;
      rst_cnt_d = (cmd_rst && is_new) ? sat_inc(rst_cnt_q) : rst_cnt_q;
      illegal_d = illegal_q | cmd_forbid;
`ifdef SR_MON_STICKY_ERR_EN
      err_d     = err_q | mismatch;
`else
      err_d     = mismatch;
`endif

      // clr takes priority over any event counted on the same edge.
      if (clr) begin
         err_cnt_d = '0;
         set_cnt_d = '0;
         rst_cnt_d = '0;
         illegal_d = 1'b0;
         err_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_UNKNOWN;
         settle_q  <= 4'd0;
         rs_prev_q <= 2'b00;
         exp_bit_q <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         illegal_q <= 1'b0;
         err_cnt_q <= '0;
         set_cnt_q <= '0;
         rst_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         rs_prev_q <= rs_prev_d;
         exp_bit_q <= exp_bit_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         illegal_q <= illegal_d;
         err_cnt_q <= err_cnt_d;
         set_cnt_q <= set_cnt_d;
         rst_cnt_q <= rst_cnt_d;
      end
   end

   assign exp_q   = exp_bit_q;
   assign valid   = valid_q;
   assign state   = state_q;
   assign err     = err_q;
   assign illegal = illegal_q;
   assign err_cnt = err_cnt_q;
   assign set_cnt = set_cnt_q;
   assign rst_cnt = rst_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch_monitor
// Purpose  : Directed self-checking bench for sr_latch_monitor. Two instances
//            share the stimulus: one with CNT_W=8 and one with CNT_W=2 (the
//            narrow one exposes counter saturation). SETTLE=2 in both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_monitor;

`ifdef SR_MON_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic clk;
   logic rst;
   logic r;
   logic s;
   logic q;
   logic clr;

   logic       a_exp_q, a_valid, a_err, a_illegal;
   logic [1:0] a_state;
   logic [7:0] a_err_cnt, a_set_cnt, a_rst_cnt;

   logic       b_exp_q, b_valid, b_err, b_illegal;
   logic [1:0] b_state;
   logic [1:0] b_err_cnt, b_set_cnt, b_rst_cnt;

   int checks = 0;
   int errors = 0;

   sr_latch_monitor #(.SETTLE(2), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .r(r), .s(s), .q(q), .clr(clr),
      .exp_q(a_exp_q), .valid(a_valid), .state(a_state), .err(a_err),
      .illegal(a_illegal), .err_cnt(a_err_cnt), .set_cnt(a_set_cnt),
      .rst_cnt(a_rst_cnt)
   );

   sr_latch_monitor #(.SETTLE(2), .CNT_W(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .r(r), .s(s), .q(q), .clr(clr),
      .exp_q(b_exp_q), .valid(b_valid), .state(b_state), .err(b_err),
      .illegal(b_illegal), .err_cnt(b_err_cnt), .set_cnt(b_set_cnt),
      .rst_cnt(b_rst_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one vector away from the edge, then sample just after the edge.
   task automatic step(input logic rr, input logic ss, input logic qq, input logic cc);
      @(negedge clk);
      r   = rr;
      s   = ss;
      q   = qq;
      clr = cc;
      @(posedge clk);
      #1;
   endtask

   // Core outputs of the wide instance plus the matching narrow-instance state.
   task automatic chk_core(input string tag, input logic [1:0] st, input logic ev,
                           input logic vl, input logic er, input logic il);
      chk({tag, "_state"},   {30'd0, a_state}, {30'd0, st});
      chk({tag, "_exp_q"},   {31'd0, a_exp_q}, {31'd0, ev});
      chk({tag, "_valid"},   {31'd0, a_valid}, {31'd0, vl});
      chk({tag, "_err"},     {31'd0, a_err},   {31'd0, er});
      chk({tag, "_illegal"}, {31'd0, a_illegal}, {31'd0, il});
      chk({tag, "_w2_state"}, {30'd0, b_state}, {30'd0, st});
   endtask

   task automatic chk_cnt(input string tag, input int ec, input int sc, input int rc,
                          input int ec2);
      chk({tag, "_err_cnt"},    {24'd0, a_err_cnt}, ec);
      chk({tag, "_set_cnt"},    {24'd0, a_set_cnt}, sc);
      chk({tag, "_rst_cnt"},    {24'd0, a_rst_cnt}, rc);
      chk({tag, "_w2_err_cnt"}, {30'd0, b_err_cnt}, ec2);
   endtask

   initial begin
      rst = 1'b1;
      r   = 1'b0;
      s   = 1'b0;
      q   = 1'b0;
      clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_core("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("reset", 0, 0, 0, 0);

      @(negedge clk);
      rst = 1'b0;

      // Hold for 5 cycles with q=1 (opposite of exp_q): nothing is compared.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk_core("idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("idle", 0, 0, 0, 0);

      // Set at edge k; q lags by one cycle.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk_core("set_k", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_cnt("set_k", 0, 1, 0, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_core("set_k1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_core("set_k2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_core("set_k3", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);

      // Reset command; q still shows the old value at the command edge.
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk_core("rcmd", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_cnt("rcmd", 0, 1, 1, 0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk_core("seq", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_cnt("seq", 0, 2, 1, 0);

      // Three mismatching compare cycles.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_core("mm1", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      chk_cnt("mm1", 1, 2, 1, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_core("mm3", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      chk_cnt("mm3", 3, 2, 1, 3);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk_core("mm_after", 2'd2, 1'b1, 1'b1, STICKY, 1'b0);
      chk_cnt("mm_after", 3, 2, 1, 3);

      // clr zeroes flags and counters but leaves state and exp_q alone.
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk_core("clr", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_cnt("clr", 0, 0, 0, 0);

      // Five mismatches: narrow instance saturates at 3.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("sat", 5, 0, 0, 3);
      chk("sat_w2_err", {31'd0, b_err}, 32'd1);
      // clr wins over a mismatch on the same edge.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_core("clr_win", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_cnt("clr_win", 0, 0, 0, 0);

      // Forbidden input for one cycle, then hold with a "wrong" q.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk_core("forbid", 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_core("ill_hold", 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_cnt("ill_hold", 0, 0, 0, 0);

      // A new set leaves ILLEGAL; illegal stays sticky.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk_core("ill_exit", 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk_cnt("ill_exit", 0, 1, 0, 0);

      // Asynchronous reset mid-SETTLING, checked before any further edge.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_core("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("async_rst", 0, 0, 0, 0);

      // First edge after release compares {r,s} against 00.
      @(negedge clk);
      rst = 1'b0;
      r   = 1'b0;
      s   = 1'b0;
      q   = 1'b0;
      @(posedge clk);
      #1;
      chk_core("post_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk_core("post_rcmd", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_cnt("post_rcmd", 0, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
